// File: rtl/rv_timer_responder.sv
`timescale 1ns/1ps
// rv_timer_responder
// ------------------
// Memory-mapped machine timer that answers on the core data-memory bus.
// It holds a 64-bit mtime counter advanced through a programmable prescaler,
// a 64-bit mtimecmp register and a registered level timer interrupt.
//
// Register map (word offset = addr[4:2], block spans BASE_ADDR..BASE_ADDR+0x1F):
//   0 mtime_lo   1 mtime_hi   2 mtimecmp_lo   3 mtimecmp_hi
//   4 ctrl (bit0 enable, bit1 irq status, read-only)
//   5 presc (low PRESC_W bits)   6,7 reserved (read 0, writes dropped)
// Out-of-range addresses behave like reserved offsets; every request gets
// exactly one rvalid pulse RESP_LAT cycles after it is accepted.
//
// Optional build macro RV_TIMER_SNAPSHOT_EN: a read of mtime_lo latches
// mtime[63:32] into a shadow register and mtime_hi reads return that shadow,
// so a lo-then-hi read pair is coherent across a carry.
//
// Ports:
//   clk, arstn                 clock, asynchronous active-low reset
//   data_req_i                 request strobe (ignored while a request is open)
//   data_we_i                  1 = write, 0 = read
//   data_be_i                  byte enables, all-zero means full word
//   data_addr_i, data_wdata_i  byte address and write data
//   data_rvalid_o              one-cycle completion pulse (reads and writes)
//   data_rdata_o               read data, valid while rvalid is high
//   timer_irq_o                enable && (mtime >= mtimecmp), registered
//
// The register layout assumes XLEN = 32 (mtime/mtimecmp are two words).

module rv_timer_responder #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = 32'h8000_1000,
  parameter int unsigned     RESP_LAT  = 1,
  parameter int unsigned     PRESC_W   = 16
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,
  output logic              timer_irq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(RESP_LAT - 1);

  // Expand byte enables to a bit mask; an all-zero enable means full word.
  function automatic logic [XLEN-1:0] be_mask(input logic [XLEN/8-1:0] be);
    logic [XLEN-1:0] m;
    for (int i = 0; i < XLEN/8; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    if (be == '0) begin
      m = '1;
    end
    return m;
  endfunction

  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old_v,
                                            input logic [XLEN-1:0] new_v,
                                            input logic [XLEN-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  state_e              state_q, state_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                irq_q, irq_d;
  logic [2*XLEN-1:0]   mtime_q, mtime_d;
  logic [2*XLEN-1:0]   mtimecmp_q, mtimecmp_d;
  logic                en_q, en_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
`ifdef RV_TIMER_SNAPSHOT_EN
  logic [XLEN-1:0]     shadow_q, shadow_d;
`endif

  // Captured request; only meaningful while the FSM is out of IDLE.
  logic                we_q, we_d;
  logic [XLEN/8-1:0]   be_q, be_d;
  logic                hit_q, hit_d;
  logic [2:0]          off_q, off_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;

  logic                cap;
  logic                commit;
  logic                tick;
  logic [XLEN-1:0]     mask;
  logic [XLEN-1:0]     rd_val;

  // Byte lane bits of the address select nothing in a word-only map.
  logic                unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, data_addr_i[1:0]};

  // Register accesses take effect on the edge that moves BUSY -> RESP.
  assign commit = (state_q == BUSY) && (lat_cnt_q == 4'd0);
  assign cap    = (state_q == IDLE) && data_req_i;
  assign tick   = en_q && (pcnt_q == presc_q);
  assign mask   = be_mask(be_q);

  // Read mux over the pre-commit register values.
  always_comb begin
    rd_val = '0;
    if (hit_q) begin
      case (off_q)
        3'd0:    rd_val = mtime_q[XLEN-1:0];
`ifdef RV_TIMER_SNAPSHOT_EN
        3'd1:    rd_val = shadow_q;
`else
        3'd1:    rd_val = mtime_q[2*XLEN-1:XLEN];
`endif
        3'd2:    rd_val = mtimecmp_q[XLEN-1:0];
        3'd3:    rd_val = mtimecmp_q[2*XLEN-1:XLEN];
        3'd4:    rd_val = {{(XLEN-2){1'b0}}, irq_q, en_q};
        3'd5:    rd_val = {{(XLEN-PRESC_W){1'b0}}, presc_q};
        default: rd_val = '0;
      endcase
    end
  end

  // Request capture
  always_comb begin
    we_d    = we_q;
    be_d    = be_q;
    hit_d   = hit_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    if (cap) begin
      we_d    = data_we_i;
      be_d    = data_be_i;
      hit_d   = (data_addr_i[XLEN-1:5] == BASE_ADDR[XLEN-1:5]);
      off_d   = data_addr_i[4:2];
      wdata_d = data_wdata_i;
    end
  end

  // FSM, counting and register writes
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rvalid_d   = commit;
    rdata_d    = rdata_q;
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
`ifdef RV_TIMER_SNAPSHOT_EN
    shadow_d   = shadow_q;
`endif
    irq_d      = en_q && (mtime_q >= mtimecmp_q);

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          state_d   = BUSY;
          lat_cnt_d = LAT_INIT;
        end
      end
      BUSY: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (en_q) begin
      if (tick) begin
        pcnt_d  = '0;
        mtime_d = mtime_q + 1'b1;
      end else begin
        pcnt_d  = pcnt_q + 1'b1;
      end
    end

    if (commit) begin
      rdata_d = we_q ? '0 : rd_val;
    end

`ifdef RV_TIMER_SNAPSHOT_EN
    if (commit && !we_q && hit_q && (off_q == 3'd0)) begin
      shadow_d = mtime_q[2*XLEN-1:XLEN];
    end
`endif

    // A bus write overrides the increment of the same cycle; an mtime write
    // leaves the other half at its current (un-incremented) value.
    if (commit && we_q && hit_q) begin
      case (off_q)
        3'd0: begin
          mtime_d = {mtime_q[2*XLEN-1:XLEN], merge(mtime_q[XLEN-1:0], wdata_q, mask)};
          pcnt_d  = '0;
        end
        3'd1: begin
          mtime_d = {merge(mtime_q[2*XLEN-1:XLEN], wdata_q, mask), mtime_q[XLEN-1:0]};
          pcnt_d  = '0;
`ifdef RV_TIMER_SNAPSHOT_EN
          shadow_d = merge(mtime_q[2*XLEN-1:XLEN], wdata_q, mask);
`endif
        end
        3'd2: mtimecmp_d[XLEN-1:0]      = merge(mtimecmp_q[XLEN-1:0], wdata_q, mask);
        3'd3: mtimecmp_d[2*XLEN-1:XLEN] = merge(mtimecmp_q[2*XLEN-1:XLEN], wdata_q, mask);
        3'd4: en_d = (wdata_q[0] & mask[0]) | (en_q & ~mask[0]);
        3'd5: begin
          presc_d = (presc_q & ~mask[PRESC_W-1:0]) | (wdata_q[PRESC_W-1:0] & mask[PRESC_W-1:0]);
          pcnt_d  = '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      presc_q    <= '0;
      pcnt_q     <= '0;
`ifdef RV_TIMER_SNAPSHOT_EN
      shadow_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      pcnt_q     <= pcnt_d;
`ifdef RV_TIMER_SNAPSHOT_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  // Request fields need no reset: the FSM gates every use of them.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    be_q    <= be_d;
    hit_q   <= hit_d;
    off_q   <= off_d;
    wdata_q <= wdata_d;
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign timer_irq_o   = irq_q;

endmodule

// File: tb/tb_rv_timer_responder.sv
`timescale 1ns/1ps
module tb_rv_timer_responder;

  localparam logic [31:0] BASE    = 32'h8000_1000;
  localparam logic [26:0] BASE_HI = BASE[31:5];
  localparam int          LAT     = 3;

  logic        clk   = 1'b0;
  logic        arstn = 1'b0;
  logic        req   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  be    = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        irq;

  rv_timer_responder #(
    .XLEN(32), .BASE_ADDR(BASE), .RESP_LAT(LAT), .PRESC_W(16)
  ) dut (
    .clk(clk), .arstn(arstn),
    .data_req_i(req), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata),
    .data_rvalid_o(rvalid), .data_rdata_o(rdata),
    .timer_irq_o(irq)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mtime is an anchor value plus the number of prescaler
  // periods elapsed since the anchor edge (counting only while enabled).
  logic [63:0] m_base;
  longint      m_pc;
  longint      m_bcyc;
  bit          m_en;
  longint      m_presc;
  logic [63:0] m_cmp;
`ifdef RV_TIMER_SNAPSHOT_EN
  logic [31:0] m_shadow;
`endif

  typedef struct {
    longint      cyc;
    logic [31:0] rdata;
    bit          we;
    bit          hit;
    logic [2:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   trk     = 1'b0;
  bit   irq_exp = 1'b0;

  function automatic logic [31:0] bmask(input logic [3:0] b);
    logic [31:0] m;
    if (b == 4'b0) return 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] m;
    m = bmask(b);
    return (o & ~m) | (n & m);
  endfunction

  // Model state after k rising edges.
  function automatic longint tot_at(input longint k);
    return m_pc + (m_en ? (k - m_bcyc) : 0);
  endfunction

  function automatic logic [63:0] mt_at(input longint k);
    return m_base + 64'(tot_at(k) / (m_presc + 1));
  endfunction

  function automatic longint pc_at(input longint k);
    return tot_at(k) % (m_presc + 1);
  endfunction

  function automatic bit irq_at(input longint k);
    logic [63:0] t;
    t = mt_at(k);
    return m_en && (t >= m_cmp);
  endfunction

  function automatic logic [31:0] read_val(input logic [2:0] off, input longint k);
    logic [63:0] t;
    t = mt_at(k);
    case (off)
      3'd0: return t[31:0];
`ifdef RV_TIMER_SNAPSHOT_EN
      3'd1: return m_shadow;
`else
      3'd1: return t[63:32];
`endif
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'b0, irq_at(k - 1), m_en};
      3'd5: return 32'(m_presc);
      default: return 32'h0;
    endcase
  endfunction

  task automatic anchor(input logic [63:0] m, input longint p, input longint k);
    m_base = m;
    m_pc   = p;
    m_bcyc = k;
  endtask

  task automatic model_reset(input longint k);
    anchor(64'h0, 0, k);
    m_en    = 1'b0;
    m_presc = 0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef RV_TIMER_SNAPSHOT_EN
    m_shadow = 32'h0;
`endif
  endtask

  // Apply the register side effects of a transaction completing at edge c.
  task automatic apply_commit(input exp_t e, input longint c);
    logic [63:0] t;
    logic [31:0] w;
    if (!e.hit) return;
    if (!e.we) begin
`ifdef RV_TIMER_SNAPSHOT_EN
      if (e.off == 3'd0) begin
        t = mt_at(c - 1);
        m_shadow = t[63:32];
      end
`endif
      return;
    end
    case (e.off)
      3'd0: begin
        t = mt_at(c - 1);
        anchor({t[63:32], merge(t[31:0], e.wdata, e.be)}, 0, c);
      end
      3'd1: begin
        t = mt_at(c - 1);
        w = merge(t[63:32], e.wdata, e.be);
        anchor({w, t[31:0]}, 0, c);
`ifdef RV_TIMER_SNAPSHOT_EN
        m_shadow = w;
`endif
      end
      3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], e.wdata, e.be);
      3'd3: m_cmp[63:32] = merge(m_cmp[63:32], e.wdata, e.be);
      3'd4: begin
        t = mt_at(c);
        anchor(t, pc_at(c), c);
        w = merge({31'b0, m_en}, e.wdata, e.be);
        m_en = w[0];
      end
      3'd5: begin
        t = mt_at(c);
        anchor(t, 0, c);
        w = merge(32'(m_presc), e.wdata, e.be);
        m_presc = longint'(w[15:0]);
      end
      default: ;
    endcase
  endtask

  // Issue one request at a falling edge while the DUT is idle; the expected
  // completion edge and read data are queued for the monitor.
  task automatic bus(input bit w, input logic [31:0] a, input logic [3:0] b,
                     input logic [31:0] d);
    exp_t e;
    bit   got;
    e.cyc   = cyc + 1 + LAT;
    e.we    = w;
    e.hit   = (a[31:5] == BASE_HI);
    e.off   = a[4:2];
    e.be    = b;
    e.wdata = d;
    e.rdata = (w || !e.hit) ? 32'h0 : read_val(a[4:2], e.cyc - 1);
    sb.push_back(e);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (rvalid === 1'b1) got = 1'b1;
    end
    req = 1'b0;
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL bus_timeout: no rvalid for addr %h, required within 40 cycles", a);
      if (sb.size() > 0) void'(sb.pop_back());
    end
    @(negedge clk);
  endtask

  // Monitor: irq every cycle, and each rvalid against the queue head.
  always @(negedge clk) begin
    if (trk && arstn) begin
      n_chk++;
      if (irq !== irq_exp) begin
        n_fail++;
        $display("FAIL irq at cycle %0d: got %b required %b", cyc, irq, irq_exp);
      end
      if (rvalid !== 1'b0) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_rvalid at cycle %0d: got %b required 0", cyc, rvalid);
        end else begin
          mon_e = sb.pop_front();
          n_chk++;
          if (cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL latency off %0d: rvalid at cycle %0d required %0d",
                     mon_e.off, cyc, mon_e.cyc);
          end
          n_chk++;
          if (rdata !== mon_e.rdata) begin
            n_fail++;
            $display("FAIL rdata off %0d we %0d: got %h required %h",
                     mon_e.off, mon_e.we, rdata, mon_e.rdata);
          end
          apply_commit(mon_e, cyc);
        end
      end
      irq_exp = irq_at(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    model_reset(0);
    arstn = 1'b0;
    repeat (3) @(negedge clk);
    model_reset(cyc);
    irq_exp = 1'b0;
    arstn   = 1'b1;
    trk     = 1'b1;
    @(negedge clk);

    // Reset state of every register
    bus(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h08, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h0C, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h14, 4'h0, 32'h0);

    // Prescaler of 5: one tick every 6 cycles
    bus(1'b1, BASE + 32'h14, 4'h0, 32'h5);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h1);
    repeat (60) @(negedge clk);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);

    // Compare match raises irq, disabling drops it
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h14, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h0C, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h08, 4'h0, 32'd20);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h1);
    got = 1'b0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (irq === 1'b1) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL irq_rise: got 0 required 1 within 100 cycles");
    end
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h10, 4'h0, 32'h0);

    // Byte enables and carry into mtime_hi
    bus(1'b1, BASE + 32'h00, 4'h0, 32'hFFFF_FFFE);
    bus(1'b1, BASE + 32'h00, 4'b0001, 32'h0000_00AA);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h00, 4'h0, 32'hFFFF_FFFF);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h1);
    repeat (3) @(negedge clk);
    bus(1'b0, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h0);

    // Misses and reserved offsets
    bus(1'b0, BASE + 32'h40, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h18, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h1C, 4'h0, 32'hDEAD_BEEF);
    bus(1'b1, BASE + 32'h28, 4'h0, 32'h0000_0055);
    bus(1'b1, BASE ^ 32'h0100_0000, 4'h0, 32'h1234_5678);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h08, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h14, 4'h0, 32'h0);

    // Low-then-high read across a carry
    bus(1'b1, BASE + 32'h14, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h00, 4'h0, 32'hFFFF_FFF0);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h1);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    repeat (20) @(negedge clk);
    bus(1'b0, BASE + 32'h04, 4'h0, 32'h0);
    bus(1'b1, BASE + 32'h10, 4'h0, 32'h0);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  off;
      logic [31:0] a, d;
      logic [3:0]  b;
      bit          w;
      off = 3'($urandom_range(0, 7));
      w   = 1'($urandom_range(0, 1));
      b   = 4'($urandom_range(0, 15));
      d   = $urandom;
      if (off == 3'd5 || off == 3'd4) d = $urandom_range(0, 3);
      a = BASE + {27'b0, off, 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a ^ (32'h1 << $urandom_range(5, 31));
      bus(w, a, b, d);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // Reset in the middle of a write
    req = 1'b1; we = 1'b1; addr = BASE + 32'h08; be = 4'h0; wdata = 32'h0000_1234;
    @(negedge clk);
    req   = 1'b0;
    arstn = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    model_reset(cyc);
    irq_exp = 1'b0;
    arstn   = 1'b1;
    repeat (8) @(negedge clk);
    bus(1'b0, BASE + 32'h08, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h00, 4'h0, 32'h0);
    bus(1'b0, BASE + 32'h10, 4'h0, 32'h0);
    repeat (4) @(negedge clk);

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_responses: got %0d outstanding required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_timer_responder.md
Name: rv_timer_responder

Overview:
- Memory-mapped machine timer that acts as a responder on the core data-memory interface (req/we/be/addr/wdata in; rvalid/rdata out).
- Sits beside the UART driver on the data bus; serves the core or an FPGA test harness acting as initiator.
- Provides a 64-bit mtime counter with a prescaler, a 64-bit mtimecmp register and a level timer interrupt.

Parameters:
- BASE_ADDR, 32'h8000_1000, base byte address; block decodes BASE_ADDR..BASE_ADDR+0x1F.
- RESP_LAT, 1, cycles from request accept to the rvalid pulse; legal range 1..15.
- PRESC_W, 16, width of the prescaler register and counter.

Ports:
- clk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- data_req_i  in  1  request strobe from initiator.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  XLEN/8  byte enables; 0 means full word.
- data_addr_i  in  XLEN  byte address.
- data_wdata_i  in  XLEN  write data.
- data_rvalid_o  out  1  one-cycle completion pulse for both reads and writes.
- data_rdata_o  out  XLEN  read data, valid while rvalid is high.
- timer_irq_o  out  1  level interrupt.

Behaviour:
- Reset values: rvalid=0, rdata=0, irq=0, mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, presc=0, prescaler counter=0, FSM=IDLE.
- FSM states:
  - IDLE: if req=1, capture we/be/addr/wdata, load the latency counter with RESP_LAT-1, go to BUSY.
  - BUSY: when the counter reaches 0, go to RESP; otherwise decrement.
  - RESP: rvalid=1 for exactly one cycle, then return to IDLE.
- Latency: rvalid rises exactly RESP_LAT cycles after the accept edge.
- req is ignored in BUSY and RESP. The initiator drops req combinationally when it sees rvalid, so back-to-back requests are accepted from IDLE at the earliest one cycle after RESP.
- Register offsets (addr[4:2]):
  - 0 mtime_lo
  - 1 mtime_hi
  - 2 mtimecmp_lo
  - 3 mtimecmp_hi
  - 4 ctrl: bit0 = enable, bit1 = irq status (read-only)
  - 5 presc: low PRESC_W bits
  - 6, 7 reserved
- Decode: addr[XLEN-1:5] must equal BASE_ADDR[XLEN-1:5]. addr[1:0] is ignored.
- Miss or reserved offset: read returns 0, write is dropped, rvalid is still pulsed (the bus never hangs).
- Write commit: on the edge entering RESP, byte-masked by be; be=0 writes all 4 bytes. Read data is registered on that same edge.
- rdata:
  - Reads: holds the read value in the RESP cycle.
  - Writes: returns 0 in the RESP cycle.
  - Otherwise holds its last value.
- Counting: when ctrl.enable=1, the prescaler counter increments each cycle. When counter==presc, the counter clears and mtime increments by 1 (presc=0 gives +1 every cycle). mtime wraps 2^64-1 -> 0 without saturation.
- A bus write to mtime_lo or mtime_hi in the same cycle as an increment: the write wins for the written half, the other half keeps its old value (no increment that cycle), and the prescaler counter clears.
- A bus write to presc clears the prescaler counter.
- irq: registered, timer_irq_o = enable && (mtime >= mtimecmp), updated every cycle from current register values. Clearing enable drops irq the next cycle.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, no rvalid is produced, and the pending write is discarded.

Optional Feature:
- Macro: RV_TIMER_SNAPSHOT_EN.
- Defined:
  - A read of mtime_lo captures mtime[63:32] into a shadow register on the same edge.
  - Reads of mtime_hi return the shadow, giving coherent 64-bit reads across a carry.
  - The shadow resets to 0.
  - Writes to mtime_hi update both mtime and the shadow.
- Not defined: mtime_hi reads return live mtime[63:32] and no shadow flop exists.

Test Plan:
- Reset, then read offset 0x10 with RESP_LAT=1 -> rvalid pulses exactly 1 cycle after accept, rdata=0, irq=0.
- RESP_LAT=3: write 0x0000_0005 to presc, write 1 to ctrl, wait 60 cycles, read mtime_lo -> value 9 or 10 (one tick per 6 cycles), and the rvalid-to-accept gap is exactly 3 cycles.
- Write mtimecmp_hi=0 and mtimecmp_lo=20 with enable=1, presc=0 -> irq rises when mtime reaches 20. Write ctrl=0 -> irq falls the next cycle, and ctrl bit1 reads 0.
- Write mtime_lo=0xFFFF_FFFE with be=4'b0001 and data 0x0000_00AA -> only byte 0 changes. be=0 with data 0xFFFF_FFFF -> full word written, then carry into mtime_hi occurs after 1 tick.
- Read address BASE_ADDR+0x40 and offset 0x18, and write to offset 0x1C -> rvalid still pulses, rdata=0, no register changes.
- With RV_TIMER_SNAPSHOT_EN: mtime=0x0000_0000_FFFF_FFF0, presc=0, read lo then read hi after the carry -> hi reads 0. Without the macro, the same sequence -> hi reads 1.
